// File: rtl/key_search_pkg.sv
// Shared types and constants for the arc4 key-search controller.
package key_search_pkg;

  localparam int KEY_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_EVAL
  } ks_state_t;

  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_MIN) && (c <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/pt_monitor.sv
// Snoops arc4 plaintext writes and judges whether the decrypted message is printable.
module pt_monitor
  import key_search_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       active,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  input  logic       pt_wren,
  output logic       ok
);

  logic [7:0] length_q, length_d;
  logic [7:0] count_q, count_d;
  logic       bad_q, bad_d;

  always_comb begin
    length_d = length_q;
    count_d  = count_q;
    bad_d    = bad_q;
    if (clr) begin
      length_d = 8'h00;
      count_d  = 8'h00;
      bad_d    = 1'b0;
    end else if (active && pt_wren) begin
      // Address 0 carries the length byte; writes beyond the length are padding.
      if (pt_addr == 8'h00) begin
        length_d = pt_wrdata;
      end else if (pt_addr <= length_q) begin
        count_d = count_q + 8'd1;
        if (!is_printable(pt_wrdata)) begin
          bad_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      length_q <= 8'h00;
      count_q  <= 8'h00;
      bad_q    <= 1'b0;
    end else begin
      length_q <= length_d;
      count_q  <= count_d;
      bad_q    <= bad_d;
    end
  end

  assign ok = !bad_q && (count_q == length_q);

endmodule

// File: rtl/key_search.sv
// Brute-force key stepper: launches arc4 per key and stops on the first printable decryption.
module key_search
  import key_search_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata,
  input  logic             pt_wren
);

  ks_state_t        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             rdy_q, rdy_d;
  logic             mon_ok;

  pt_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_LAUNCH),
    .active    (state_q == ST_RUN),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .ok        (mon_ok)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          key_d       = KEY_START;
          key_valid_d = 1'b0;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (arc4_rdy) state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!arc4_rdy) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (arc4_rdy) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (mon_ok) begin
          key_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (key_q == KEY_LAST) begin
          key_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          key_d   = key_q + 24'd1;
          state_d = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready tracks the state we are about to enter.
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      rdy_q       <= rdy_d;
    end
  end

  assign arc4_en   = (state_q == ST_LAUNCH) && arc4_rdy;
  assign rdy       = rdy_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_key_search.sv
// Directed bench for key_search with a behavioural arc4 stub shared by two instances.
module tb_key_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        rdy_a, rdy_b;
  logic [23:0] key_a, key_b;
  logic        kv_a, kv_b;
  logic        arc4_en_a, arc4_en_b;
  logic        arc4_rdy;
  logic [7:0]  pt_addr, pt_wrdata;
  logic        pt_wren;

  int tests = 0;
  int fails = 0;

  // Stub configuration: the "good" pattern is written only for good_key.
  logic [23:0] good_key;
  logic [7:0]  pat_addr [0:127];
  logic [7:0]  pat_data [0:127];
  int          pat_n;
  logic        stub_busy;
  int          pulse_cnt = 0;
  int          dbl_cnt = 0;
  logic        en_prev = 1'b0;

  logic [23:0] launch_key;
  logic        launch_en;
  logic        launch_rdy;

  always #5 clk = ~clk;

  key_search #(.KEY_START(24'h1E45FE), .KEY_LAST(24'hFFFFFF)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key_a), .key_valid(kv_a),
    .arc4_en(arc4_en_a), .arc4_rdy(arc4_rdy), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
    .pt_wren(pt_wren)
  );

  key_search #(.KEY_START(24'hFFFFFE), .KEY_LAST(24'hFFFFFF)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b), .key_valid(kv_b),
    .arc4_en(arc4_en_b), .arc4_rdy(arc4_rdy), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
    .pt_wren(pt_wren)
  );

  always @(negedge clk) begin
    if (arc4_en_a || arc4_en_b) pulse_cnt++;
    if ((arc4_en_a || arc4_en_b) && en_prev) dbl_cnt++;
    en_prev = arc4_en_a || arc4_en_b;
  end

  // Behavioural arc4: busy one cycle after the start pulse, then writes, ready with the last write.
  initial begin : stub
    logic [23:0] cur_key;
    int n;
    arc4_rdy = 1'b1; pt_wren = 1'b0; pt_addr = 8'h00; pt_wrdata = 8'h00; stub_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (arc4_en_a || arc4_en_b) begin
        stub_busy = 1'b1;
        cur_key = arc4_en_a ? key_a : key_b;
        @(posedge clk); #1 arc4_rdy = 1'b0;
        @(posedge clk); #1;
        n = (cur_key == good_key) ? pat_n : 2;
        for (int i = 0; i < n; i++) begin
          pt_wren = 1'b1;
          if (cur_key == good_key) begin
            pt_addr = pat_addr[i]; pt_wrdata = pat_data[i];
          end else begin
            pt_addr = 8'(i); pt_wrdata = (i == 0) ? 8'h01 : 8'h7F;
          end
          if (i == n - 1) arc4_rdy = 1'b1;
          @(posedge clk); #1;
        end
        pt_wren = 1'b0;
        arc4_rdy = 1'b1;
        stub_busy = 1'b0;
      end
    end
  end

  task automatic start(input bit use_b);
    @(posedge clk); #1;
    if (use_b) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0;
    launch_key = use_b ? key_b : key_a;
    launch_en  = use_b ? arc4_en_b : arc4_en_a;
    launch_rdy = use_b ? rdy_b : rdy_a;
  endtask

  task automatic wait_done(input bit use_b, input string name);
    int c = 0;
    while (((use_b ? rdy_b : rdy_a) !== 1'b1) && c < 20000) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 20000) begin
      tests++; fails++;
      $display("FAIL %s: rdy timeout after %0d cycles, required rdy=1", name, c);
    end
  endtask

  task automatic wait_wren(input string name);
    int c = 0;
    while (pt_wren !== 1'b1 && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 2000) begin
      tests++; fails++;
      $display("FAIL %s: no pt_wren seen, required a write", name);
    end
  endtask

  task automatic set_one_char(input logic [7:0] ch);
    pat_addr[0] = 8'h00; pat_data[0] = 8'h01;
    pat_addr[1] = 8'h01; pat_data[1] = ch;
    pat_n = 2;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b required 0", rdy_a); end
    tests++; if (key_a !== 24'h0) begin fails++; $display("FAIL reset_key: got %h required 000000", key_a); end
    tests++; if (kv_a !== 1'b0) begin fails++; $display("FAIL reset_kv: got %b required 0", kv_a); end
    tests++; if (arc4_en_a !== 1'b0) begin fails++; $display("FAIL reset_arc4_en: got %b required 0", arc4_en_a); end
    @(negedge clk); rst = 1'b0;
    #1;
    tests++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL rel_rdy_pre: got %b required 0", rdy_a); end
    @(posedge clk); #1;
    tests++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL rel_rdy_post: got %b required 1", rdy_a); end
  endtask

  task automatic test_found;
    int base;
    good_key = 24'h1E4600;
    pat_addr[0] = 8'h00; pat_data[0] = 8'h49;
    for (int i = 1; i <= 8'h49; i++) begin
      pat_addr[i] = 8'(i); pat_data[i] = 8'h41 + 8'(i % 26);
    end
    pat_n = 8'h4A;
    base = pulse_cnt;
    start(1'b0);
    tests++; if (launch_rdy !== 1'b0) begin fails++; $display("FAIL found_rdy_fall: got %b required 0", launch_rdy); end
    tests++; if (launch_en !== 1'b1) begin fails++; $display("FAIL found_launch_en: got %b required 1", launch_en); end
    tests++; if (launch_key !== 24'h1E45FE) begin fails++; $display("FAIL found_launch_key: got %h required 1e45fe", launch_key); end
    wait_done(1'b0, "found");
    tests++; if (pulse_cnt - base !== 3) begin fails++; $display("FAIL found_pulses: got %0d required 3", pulse_cnt - base); end
    tests++; if (key_a !== 24'h1E4600) begin fails++; $display("FAIL found_key: got %h required 1e4600", key_a); end
    tests++; if (kv_a !== 1'b1) begin fails++; $display("FAIL found_kv: got %b required 1", kv_a); end
  endtask

  task automatic test_exhausted;
    int base;
    good_key = 24'h000000;
    base = pulse_cnt;
    start(1'b1);
    wait_done(1'b1, "exhausted");
    repeat (10) @(posedge clk);
    #1;
    tests++; if (pulse_cnt - base !== 2) begin fails++; $display("FAIL exh_pulses: got %0d required 2", pulse_cnt - base); end
    tests++; if (key_b !== 24'hFFFFFF) begin fails++; $display("FAIL exh_key: got %h required ffffff", key_b); end
    tests++; if (kv_b !== 1'b0) begin fails++; $display("FAIL exh_kv: got %b required 0", kv_b); end
  endtask

  task automatic test_char_bounds;
    logic [7:0] chars [0:3];
    logic       exp_v [0:3];
    chars[0] = 8'h20; exp_v[0] = 1'b1;
    chars[1] = 8'h7E; exp_v[1] = 1'b1;
    chars[2] = 8'h1F; exp_v[2] = 1'b0;
    chars[3] = 8'h7F; exp_v[3] = 1'b0;
    good_key = 24'hFFFFFE;
    for (int i = 0; i < 4; i++) begin
      set_one_char(chars[i]);
      start(1'b1);
      wait_done(1'b1, "char");
      tests++;
      if (kv_b !== exp_v[i] || key_b !== (exp_v[i] ? 24'hFFFFFE : 24'hFFFFFF)) begin
        fails++;
        $display("FAIL char_%h: got kv=%b key=%h required kv=%b", chars[i], kv_b, key_b, exp_v[i]);
      end
    end
    pat_addr[0] = 8'h00; pat_data[0] = 8'h03;
    pat_addr[1] = 8'h01; pat_data[1] = 8'h41;
    pat_addr[2] = 8'h02; pat_data[2] = 8'h42;
    pat_addr[3] = 8'h03; pat_data[3] = 8'h43;
    pat_addr[4] = 8'h05; pat_data[4] = 8'h01;
    pat_n = 5;
    start(1'b1);
    wait_done(1'b1, "beyond_len");
    tests++;
    if (kv_b !== 1'b1 || key_b !== 24'hFFFFFE) begin
      fails++; $display("FAIL beyond_len: got kv=%b key=%h required kv=1 key=fffffe", kv_b, key_b);
    end
  endtask

  task automatic test_short_msg;
    int base;
    good_key = 24'hFFFFFE;
    pat_addr[0] = 8'h00; pat_data[0] = 8'h05;
    for (int i = 1; i <= 4; i++) begin
      pat_addr[i] = 8'(i); pat_data[i] = 8'h61;
    end
    pat_n = 5;
    base = pulse_cnt;
    start(1'b1);
    wait_done(1'b1, "short");
    tests++;
    if (kv_b !== 1'b0 || key_b !== 24'hFFFFFF || pulse_cnt - base !== 2) begin
      fails++; $display("FAIL short_msg: got kv=%b key=%h pulses=%0d required kv=0 key=ffffff pulses=2", kv_b, key_b, pulse_cnt - base);
    end
    pat_addr[0] = 8'h00; pat_data[0] = 8'h00;
    pat_n = 1;
    start(1'b1);
    wait_done(1'b1, "len0");
    tests++;
    if (kv_b !== 1'b1 || key_b !== 24'hFFFFFE) begin
      fails++; $display("FAIL len0: got kv=%b key=%h required kv=1 key=fffffe", kv_b, key_b);
    end
  endtask

  task automatic test_en_ignored;
    int base;
    good_key = 24'h1E45FF;
    set_one_char(8'h55);
    base = pulse_cnt;
    start(1'b0);
    wait_wren("en_run");
    en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    wait_done(1'b0, "en_run");
    tests++;
    if (kv_a !== 1'b1 || key_a !== 24'h1E45FF || pulse_cnt - base !== 2) begin
      fails++; $display("FAIL en_in_run: got kv=%b key=%h pulses=%0d required kv=1 key=1e45ff pulses=2", kv_a, key_a, pulse_cnt - base);
    end
  endtask

  task automatic test_reset_in_run;
    int c = 0;
    good_key = 24'h000000;
    start(1'b0);
    wait_wren("rst_run");
    @(negedge clk); rst = 1'b1;
    #1;
    tests++;
    if (rdy_a !== 1'b0 || key_a !== 24'h0 || kv_a !== 1'b0 || arc4_en_a !== 1'b0) begin
      fails++; $display("FAIL rst_in_run: got rdy=%b key=%h kv=%b en=%b required all zero", rdy_a, key_a, kv_a, arc4_en_a);
    end
    while (stub_busy && c < 2000) begin @(posedge clk); #1; c++; end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL rst_run_rdy: got %b required 1", rdy_a); end
  endtask

  task automatic test_restart;
    int base;
    good_key = 24'h1E45FE;
    set_one_char(8'h30);
    base = pulse_cnt;
    start(1'b0);
    tests++; if (launch_key !== 24'h1E45FE) begin fails++; $display("FAIL restart_key: got %h required 1e45fe", launch_key); end
    wait_done(1'b0, "restart");
    tests++;
    if (kv_a !== 1'b1 || key_a !== 24'h1E45FE || pulse_cnt - base !== 1) begin
      fails++; $display("FAIL restart_result: got kv=%b key=%h pulses=%0d required kv=1 key=1e45fe pulses=1", kv_a, key_a, pulse_cnt - base);
    end
    tests++; if (dbl_cnt !== 0) begin fails++; $display("FAIL arc4_en_width: got %0d double pulses required 0", dbl_cnt); end
  endtask

  initial begin
    good_key = 24'h0;
    pat_n = 0;
    test_reset;
    test_found;
    test_exhausted;
    test_char_bounds;
    test_short_msg;
    test_en_ignored;
    test_reset_in_run;
    test_restart;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
